load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory interface (mem_read/mem_write/address/write_data/read_data).
//  Accepts byte-addressed RV64 load/store requests from the sequential core via valid/ready.
//  Converts each request to doubleword-indexed accesses; sub-doubleword stores use read-modify-write.
//  Returns aligned, sign/zero-extended load data, or an error, through a one-cycle response pulse.
// PARAMETERS
//  MEM_WORDS  256  number of 64-bit words in the attached data memory; word index >= MEM_WORDS is an error
// PORTS
//  clk             in   1   system clock, all state on rising edge
//  rst_n           in   1   asynchronous active-low reset
//  req_valid       in   1   request present
//  req_ready       out  1   unit can accept; high only in IDLE
//  req_we          in   1   1=store, 0=load
//  req_funct3      in   3   RV64 width code (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD)
//  req_addr        in   64  byte address
//  req_wdata       in   64  store data, right-justified
//  resp_valid      out  1   one-cycle completion pulse
//  resp_rdata      out  64  load result (0 for stores and errors)
//  resp_err        out  1   misaligned / out-of-range / illegal funct3; valid with resp_valid
//  mem_read        out  1   to data memory
//  mem_write       out  1   to data memory
//  mem_address     out  64  word index = {3'b0, addr[63:3]}
//  mem_write_data  out  64  merged doubleword
//  mem_read_data   in   64  from data memory, combinational in the same cycle as mem_read
// BEHAVIOUR
//  - Reset (async, rst_n low): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0,
//    mem_write=0, mem_address=0, mem_write_data=0; req_ready=1 once in IDLE.
//  - FSM IDLE -> ACCESS -> (WRITE) -> RESP -> IDLE. Handshake: accept when req_valid&&req_ready (cycle T);
//    latch we/funct3/addr/wdata. Inputs are ignored outside IDLE.
//  - Checks at accept: loads funct3=111 and stores funct3>=100 illegal; H needs addr[0]=0, W needs
//    addr[1:0]=0, D needs addr[2:0]=0; addr[63:3]>=MEM_WORDS out of range. On any error: IDLE->RESP,
//    resp_valid=1, resp_err=1, resp_rdata=0 at T+1; mem_read/mem_write never asserted.
//  - ACCESS (T+1): mem_read=1, mem_address=word index. Load: select lanes by addr[2:0] (little-endian,
//    byte k = bits[8k+7:8k]), sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU/LD), register -> RESP.
//    Store: merge req_wdata low bytes into mem_read_data at lane offset, register -> WRITE.
//  - WRITE (T+2): mem_write=1 for exactly one cycle, mem_read=0, mem_write_data=merged word.
//  - RESP: resp_valid=1 for exactly one cycle; no backpressure. Load resp at T+2, store resp at T+3.
//  - Outside ACCESS/WRITE: mem_read=0, mem_write=0, mem_address=0 (memory returns 0).
//  - resp_rdata/resp_err hold 0 when resp_valid=0.
//  - Back-to-back: next request accepted the cycle after RESP (IDLE).
//  - Reset mid-operation: FSM aborts immediately; mem_write drops combinationally; no partial write.
// CONFIGURATION
//  LSU_SD_BYPASS_EN defined: SD (full doubleword, aligned) skips ACCESS: IDLE->WRITE, mem_write at T+1,
//    mem_write_data=req_wdata, resp at T+2. Other stores unchanged.
//  Undefined: SD follows the generic read-modify-write path (write T+2, resp T+3).
// TESTING
//  1. mem[2]=0x8877665544332211; LB addr 0x17 -> resp_rdata=0xFFFFFFFFFFFFFF88 at T+2; LBU -> 0x88.
//  2. Same mem; LW addr 0x14 -> 0xFFFFFFFF88776655; LWU -> 0x0000000088776655; LD 0x10 -> full word.
//  3. SH addr 0x12 wdata 0xABCD -> mem_write once at T+2, mem[2]=0x88776655ABCD2211, resp_err=0 at T+3.
//  4. LW addr 0x16 -> resp_valid=1, resp_err=1, resp_rdata=0 at T+1; mem_read, mem_write stay 0.
//  5. LD addr 0x800 (word 256) -> error at T+1; store funct3=100 -> error; memory unchanged.
//  6. SD addr 0x08, rst_n low during T+1 -> no mem_write, mem[1] unchanged, req_ready=1 after release;
//     with LSU_SD_BYPASS_EN, SD 0x08 -> mem_write at T+1, resp at T+2.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-request / response / data-memory bundle for the load/store unit.
// slave = the LSU's view, master = the environment (core + memory) view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store unit: byte-addressed requests -> doubleword memory accesses,
// sub-doubleword stores by read-modify-write. Option macro: LSU_SD_BYPASS_EN.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;

  logic        req_err;
  logic        misalign;
  logic [5:0]  sh;
  logic [63:0] lane_data;
  logic [63:0] load_data;
  logic [63:0] size_mask;
  logic [63:0] merged;

  assign bus.req_ready = (state_q == IDLE);

  always_comb begin
    misalign = 1'b0;
    case (bus.req_funct3[1:0])
      2'd1:    misalign = bus.req_addr[0];
      2'd2:    misalign = |bus.req_addr[1:0];
      2'd3:    misalign = |bus.req_addr[2:0];
      default: misalign = 1'b0;
    endcase
    req_err = misalign
            | (bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111))
            | (bus.req_addr[63:3] >= 61'(MEM_WORDS));
  end

  // Loads shift the addressed lane down to bit 0, then extend by width code.
  assign sh        = {off_q, 3'b000};
  assign lane_data = bus.mem_read_data >> sh;

  always_comb begin
    load_data = 64'h0;
    case (f3_q)
      3'b000:  load_data = {{56{lane_data[7]}},  lane_data[7:0]};
      3'b001:  load_data = {{48{lane_data[15]}}, lane_data[15:0]};
      3'b010:  load_data = {{32{lane_data[31]}}, lane_data[31:0]};
      3'b011:  load_data = lane_data;
      3'b100:  load_data = {56'h0, lane_data[7:0]};
      3'b101:  load_data = {48'h0, lane_data[15:0]};
      3'b110:  load_data = {32'h0, lane_data[31:0]};
      default: load_data = 64'h0;
    endcase
  end

  always_comb begin
    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (f3_q[1:0])
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    merged = (bus.mem_read_data & ~(size_mask << sh)) | ((wdata_q & size_mask) << sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      we_q               <= 1'b0;
      f3_q               <= 3'b000;
      off_q              <= 3'b000;
      wdata_q            <= 64'h0;
      bus.resp_valid     <= 1'b0;
      bus.resp_rdata     <= 64'h0;
      bus.resp_err       <= 1'b0;
      bus.mem_read       <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_address    <= 64'h0;
      bus.mem_write_data <= 64'h0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          we_q    <= bus.req_we;
          f3_q    <= bus.req_funct3;
          off_q   <= bus.req_addr[2:0];
          wdata_q <= bus.req_wdata;
          if (req_err) begin
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            state_q        <= RESP;
          end
`ifdef LSU_SD_BYPASS_EN
          // Full aligned doubleword needs no merge: write straight away.
          else if (bus.req_we && bus.req_funct3 == 3'b011) begin
            bus.mem_write      <= 1'b1;
            bus.mem_address    <= {3'b000, bus.req_addr[63:3]};
            bus.mem_write_data <= bus.req_wdata;
            state_q            <= WRITE;
          end
`endif
          else begin
            bus.mem_read    <= 1'b1;
            bus.mem_address <= {3'b000, bus.req_addr[63:3]};
            state_q         <= ACCESS;
          end
        end
        ACCESS: begin
          bus.mem_read <= 1'b0;
          if (we_q) begin
            bus.mem_write      <= 1'b1;
            bus.mem_write_data <= merged;
            state_q            <= WRITE;
          end else begin
            bus.mem_address <= 64'h0;
            bus.resp_valid  <= 1'b1;
            bus.resp_rdata  <= load_data;
            state_q         <= RESP;
          end
        end
        WRITE: begin
          bus.mem_write      <= 1'b0;
          bus.mem_address    <= 64'h0;
          bus.mem_write_data <= 64'h0;
          bus.resp_valid     <= 1'b1;
          state_q            <= RESP;
        end
        default: begin
          bus.resp_valid <= 1'b0;
          bus.resp_rdata <= 64'h0;
          bus.resp_err   <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a negedge monitor pops and compares them against the DUT and a word-array memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [63:0] mem [256];

  assign bus.mem_read_data = (bus.mem_read && bus.mem_address < 64'd256)
                           ? mem[bus.mem_address[7:0]] : 64'h0;

  always @(posedge clk)
    if (bus.mem_write && bus.mem_address < 64'd256)
      mem[bus.mem_address[7:0]] <= bus.mem_write_data;

`ifdef LSU_SD_BYPASS_EN
  localparam int LAT_SD = 2;
  localparam int RDC_SD = 0;
`else
  localparam int LAT_SD = 3;
  localparam int RDC_SD = 1;
`endif

  typedef struct {
    string       name;
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   wr_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: pops expected responses, and checks idle values between responses.
  always @(negedge clk) begin
    if (bus.mem_write) begin wr_cnt++; wr_cyc = cyc; end
    if (bus.mem_read)  rd_cnt++;
    if (!bus.mem_read && !bus.mem_write) chk("idle_mem_address", bus.mem_address, 64'h0);
    if (bus.resp_valid) begin
      if (sb.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
        chk({e.name, "_err"}, 64'(bus.resp_err), 64'(e.err));
        chk({e.name, "_resp_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end else begin
      chk("idle_resp", {bus.resp_rdata[62:0], bus.resp_err}, 64'h0);
    end
  end

  task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_err,
                       input int lat, input int exp_wr, input int exp_rdc);
    int t, w0, r0, k;
    exp_t e;
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    chk({nm, "_ready"}, 64'(bus.req_ready), 64'd1);
    w0 = wr_cnt; r0 = rd_cnt; t = cyc;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    e.name = nm; e.rdata = exp_rd; e.err = exp_err; e.cyc = t + lat;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    k = 0;
    while (sb.size() != 0 && k < 20) begin @(negedge clk); k++; end
    if (sb.size() != 0) begin
      chk({nm, "_timeout"}, 64'd1, 64'd0);
      sb.delete();
    end
    @(negedge clk);
    chk({nm, "_write_count"}, 64'(wr_cnt - w0), 64'(exp_wr));
    chk({nm, "_read_count"}, 64'(rd_cnt - r0), 64'(exp_rdc));
    if (exp_wr != 0) chk({nm, "_write_cycle"}, 64'(wr_cyc), 64'(t + lat - 1));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 64'h0; bus.req_wdata = 64'h0;
    for (int i = 0; i < 256; i++) mem[i] <= 64'h0;
    mem[1] <= 64'h1111_2222_3333_4444;
    mem[2] <= 64'h8877_6655_4433_2211;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mem_ctrl", {62'h0, bus.mem_read, bus.mem_write}, 64'h0);
    chk("rst_mem_wdata", bus.mem_write_data, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Loads from mem[2] = 0x8877665544332211
    issue("LB_17",  1'b0, 3'b000, 64'h17, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 2, 0, 1);
    issue("LBU_17", 1'b0, 3'b100, 64'h17, 64'h0, 64'h0000_0000_0000_0088, 1'b0, 2, 0, 1);
    issue("LW_14",  1'b0, 3'b010, 64'h14, 64'h0, 64'hFFFF_FFFF_8877_6655, 1'b0, 2, 0, 1);
    issue("LWU_14", 1'b0, 3'b110, 64'h14, 64'h0, 64'h0000_0000_8877_6655, 1'b0, 2, 0, 1);
    issue("LD_10",  1'b0, 3'b011, 64'h10, 64'h0, 64'h8877_6655_4433_2211, 1'b0, 2, 0, 1);
    issue("LH_12",  1'b0, 3'b001, 64'h12, 64'h0, 64'h0000_0000_0000_4433, 1'b0, 2, 0, 1);
    issue("LHU_16", 1'b0, 3'b101, 64'h16, 64'h0, 64'h0000_0000_0000_8877, 1'b0, 2, 0, 1);

    // Halfword read-modify-write, upper wdata bits must be ignored
    issue("SH_12", 1'b1, 3'b001, 64'h12, 64'h1234_5678_9ABC_ABCD, 64'h0, 1'b0, 3, 1, 1);
    chk("SH_12_mem2", mem[2], 64'h8877_6655_ABCD_2211);
    issue("LD_10b", 1'b0, 3'b011, 64'h10, 64'h0, 64'h8877_6655_ABCD_2211, 1'b0, 2, 0, 1);

    // Errors: no memory traffic, response at T+1
    issue("LW_16_misal", 1'b0, 3'b010, 64'h16,  64'h0, 64'h0, 1'b1, 1, 0, 0);
    issue("LD_800_oor",  1'b0, 3'b011, 64'h800, 64'h0, 64'h0, 1'b1, 1, 0, 0);
    issue("ST_f3_100",   1'b1, 3'b100, 64'h10,  64'hFF, 64'h0, 1'b1, 1, 0, 0);
    issue("LD_f3_111",   1'b0, 3'b111, 64'h10,  64'h0, 64'h0, 1'b1, 1, 0, 0);
    issue("SD_0c_misal", 1'b1, 3'b011, 64'h0C,  64'h5, 64'h0, 1'b1, 1, 0, 0);
    chk("err_mem2_unchanged", mem[2], 64'h8877_6655_ABCD_2211);

    // Last valid word, doubleword store and narrower merges on word 3
    issue("LD_7f8", 1'b0, 3'b011, 64'h7F8, 64'h0, 64'h0, 1'b0, 2, 0, 1);
    issue("SD_18", 1'b1, 3'b011, 64'h18, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0, LAT_SD, 1, RDC_SD);
    chk("SD_18_mem3", mem[3], 64'hDEAD_BEEF_CAFE_F00D);
    issue("SB_1f", 1'b1, 3'b000, 64'h1F, 64'h0000_0000_0000_005A, 64'h0, 1'b0, 3, 1, 1);
    chk("SB_1f_mem3", mem[3], 64'h5AAD_BEEF_CAFE_F00D);
    issue("SW_1c", 1'b1, 3'b010, 64'h1C, 64'hFFFF_FFFF_0102_0304, 64'h0, 1'b0, 3, 1, 1);
    chk("SW_1c_mem3", mem[3], 64'h0102_0304_CAFE_F00D);
    issue("LB_18", 1'b0, 3'b000, 64'h18, 64'h0, 64'h0000_0000_0000_000D, 1'b0, 2, 0, 1);

    // Reset during T+1 of an SD: no write may land
    begin
      int w0;
      w0 = wr_cnt;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b011;
      bus.req_addr = 64'h08; bus.req_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
      @(posedge clk);
      #1 rst_n = 1'b0;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_mem_write", 64'(bus.mem_write), 64'd0);
      chk("rst_mid_ready", 64'(bus.req_ready), 64'd1);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_mid_ready_after", 64'(bus.req_ready), 64'd1);
      chk("rst_mid_mem1", mem[1], 64'h1111_2222_3333_4444);
      chk("rst_mid_writes", 64'(wr_cnt - w0), 64'd0);
    end

    issue("SD_08", 1'b1, 3'b011, 64'h08, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, LAT_SD, 1, RDC_SD);
    chk("SD_08_mem1", mem[1], 64'h0123_4567_89AB_CDEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
